ddr_adc_chk_ctrl: RTL and testbench

Run controller for the 512-bit ADC pattern checker on the DDR readback path. It sequences one check run: a one-cycle clear of the checker, beat counting against a programmed target, an idle timeout and software abort, a drain, and a snapshot of the checker's success/error counters. It publishes a pass/fail verdict to the register bank. It sits beside the checker, drives the checker's cfg_rst, and monitors the same adc_vld strobe.

---
 rtl/ddr_adc_chk_ctrl_if.sv | 38 +++
 rtl/ddr_adc_chk_ctrl.sv | 132 +++++++++++++
 tb/tb_ddr_adc_chk_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_adc_chk_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ddr_adc_chk_ctrl_if : run-control / checker-counter bundle for the ADC   |
// | pattern-checker run controller.                  rev 1.0                 |
// +-------------------------------------------------------------------------+
interface ddr_adc_chk_ctrl_if #(
   parameter int CNT_WD = 32
);
   logic              start;
   logic              stop;
   logic [CNT_WD-1:0] beat_target;
   logic [CNT_WD-1:0] timeout_cyc;
   logic              adc_vld;
   logic [CNT_WD-1:0] suc_cnt;
   logic [CNT_WD-1:0] err_cnt;
   logic              chk_rst;
   logic              busy;
   logic              done;
   logic              pass;
   logic              timeout_flag;
   logic              abort_flag;
   logic [CNT_WD-1:0] beat_cnt;
   logic [CNT_WD-1:0] res_suc;
   logic [CNT_WD-1:0] res_err;

   modport master (
      output start, stop, beat_target, timeout_cyc, adc_vld, suc_cnt, err_cnt,
      input  chk_rst, busy, done, pass, timeout_flag, abort_flag,
             beat_cnt, res_suc, res_err
   );

   modport slave (
      input  start, stop, beat_target, timeout_cyc, adc_vld, suc_cnt, err_cnt,
      output chk_rst, busy, done, pass, timeout_flag, abort_flag,
             beat_cnt, res_suc, res_err
   );
endinterface
`default_nettype wire

// File: rtl/ddr_adc_chk_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ddr_adc_chk_ctrl : sequences one ADC pattern-check run and publishes a   |
// | pass/fail verdict plus checker counter snapshots.  rev 1.0               |
// +-------------------------------------------------------------------------+
module ddr_adc_chk_ctrl #(
   parameter int CNT_WD = 32
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   ddr_adc_chk_ctrl_if.slave bus
);
   localparam logic [CNT_WD-1:0] ONES = '1;
   localparam logic [CNT_WD-1:0] ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic              drain_sub;
   logic [CNT_WD-1:0] tgt, tmo, idle_cnt;
   logic              exit_abort, exit_tmo, pass_nx;

   logic              chk_rst_q, busy_q, done_q, pass_q, tmo_flag_q, abort_q;
   logic [CNT_WD-1:0] beat_q, res_suc_q, res_err_q;

   assign bus.chk_rst      = chk_rst_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.timeout_flag = tmo_flag_q;
   assign bus.abort_flag   = abort_q;
   assign bus.beat_cnt     = beat_q;
   assign bus.res_suc      = res_suc_q;
   assign bus.res_err      = res_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      exit_abort = 1'b0;
      exit_tmo   = 1'b0;
      case (state)
         IDLE, DONE: if (bus.start) state_nx = CLR;
         CLR:        state_nx = RUN;
         RUN: begin
            if (bus.stop) begin
               state_nx   = DRAIN;
               exit_abort = 1'b1;
            end else if (tgt != '0 && bus.adc_vld && beat_q == tgt - ONE) begin
               state_nx = DRAIN;
            end else if (tmo != '0 && !bus.adc_vld && idle_cnt == tmo - ONE) begin
               state_nx = DRAIN;
               exit_tmo = 1'b1;
            end
         end
         DRAIN:      if (drain_sub) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // Verdict uses the live checker counters, sampled on the same edge as the snapshot.
   assign pass_nx = !abort_q && !tmo_flag_q && (bus.err_cnt == '0) &&
                    (bus.suc_cnt == beat_q) && (beat_q == tgt) && (tgt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_rst_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         tmo_flag_q <= 1'b0;
         abort_q    <= 1'b0;
         beat_q     <= '0;
         res_suc_q  <= '0;
         res_err_q  <= '0;
         tgt        <= '0;
         tmo        <= '0;
         idle_cnt   <= '0;
         drain_sub  <= 1'b0;
      end else begin
         chk_rst_q <= (state_nx == CLR);
         busy_q    <= (state_nx == CLR) || (state_nx == RUN) || (state_nx == DRAIN);
         done_q    <= (state_nx == DONE);
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  tgt        <= bus.beat_target;
                  tmo        <= bus.timeout_cyc;
                  beat_q     <= '0;
                  idle_cnt   <= '0;
                  tmo_flag_q <= 1'b0;
                  abort_q    <= 1'b0;
                  res_suc_q  <= '0;
                  res_err_q  <= '0;
                  pass_q     <= 1'b0;
               end
            end
            CLR: drain_sub <= 1'b0;
            RUN: begin
               drain_sub <= 1'b0;
               if (bus.adc_vld) begin
                  if (beat_q != ONES) beat_q <= beat_q + ONE;
                  idle_cnt <= '0;
               end else if (idle_cnt != ONES) begin
                  idle_cnt <= idle_cnt + ONE;
               end
               if (exit_abort) abort_q    <= 1'b1;
               if (exit_tmo)   tmo_flag_q <= 1'b1;
            end
            DRAIN: begin
               drain_sub <= 1'b1;
               if (drain_sub) begin
                  res_suc_q <= bus.suc_cnt;
                  res_err_q <= bus.err_cnt;
                  pass_q    <= pass_nx;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ddr_adc_chk_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ddr_adc_chk_ctrl : table, hand-sequence and random checks of the run  |
// | controller against a cycle-indexed behavioural model.  rev 1.0           |
// +-------------------------------------------------------------------------+
module tb_ddr_adc_chk_ctrl;
   localparam int CNT_WD = 32;
   localparam int NA     = 256;

   logic clk = 1'b0;
   logic rst_n;
   logic bad;
   always #5 clk = ~clk;

   ddr_adc_chk_ctrl_if #(.CNT_WD(CNT_WD)) bus ();
   ddr_adc_chk_ctrl #(.CNT_WD(CNT_WD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Checker stand-in: counters include the beat presented in the current cycle.
   logic [31:0] suc_q, err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || bus.chk_rst) begin
         suc_q <= '0;
         err_q <= '0;
      end else if (bus.adc_vld) begin
         if (bad) err_q <= err_q + 32'd1;
         else     suc_q <= suc_q + 32'd1;
      end
   end
   assign bus.suc_cnt = suc_q + {31'd0, bus.adc_vld && !bad && !bus.chk_rst};
   assign bus.err_cnt = err_q + {31'd0, bus.adc_vld &&  bad && !bus.chk_rst};

   bit vld_a [NA];
   bit bad_a [NA];
   bit stp_a [NA];
   bit sta_a [NA];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int tgt, tmo, nb, bad_idx, stop_at, start_at;
      int e_done, e_beat, e_suc, e_err, e_pass, e_ab, e_to;
   } vec_t;

   typedef struct {
      int done, beat, suc, err, pass, ab, to;
   } res_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_arrays();
      for (int i = 0; i < NA; i++) begin
         vld_a[i] = 0; bad_a[i] = 0; stp_a[i] = 0; sta_a[i] = 0;
      end
   endtask

   // Run-level model: cycle 0 is the first RUN cycle; done appears 3 cycles after the exit cycle.
   function automatic res_t model(input int tgt, input int tmo, input int ncyc);
      res_t r;
      int beats = 0, idle = 0, e = -1;
      r = '{default: 0};
      for (int i = 0; i < ncyc; i++) begin
         if (vld_a[i]) begin beats++; idle = 0; end
         else idle++;
         if (stp_a[i]) begin r.ab = 1; e = i; break; end
         if (tgt != 0 && vld_a[i] && beats == tgt) begin e = i; break; end
         if (tmo != 0 && !vld_a[i] && idle == tmo) begin r.to = 1; e = i; break; end
      end
      if (e < 0) begin
         r.done = -1;
         return r;
      end
      for (int i = 0; i <= e + 2; i++)
         if (vld_a[i]) begin
            if (bad_a[i]) r.err++;
            else          r.suc++;
         end
      r.done = e + 3;
      r.beat = beats;
      r.pass = (!r.ab && !r.to && r.err == 0 && r.suc == beats && beats == tgt && tgt != 0) ? 1 : 0;
      return r;
   endfunction

   task automatic do_run(input int tgt, input int tmo, input int ncyc,
                         input bit with_stop, input string tag, output int done_cyc);
      int glitch;
      @(negedge clk);
      bus.start       = 1'b1;
      bus.stop        = with_stop;
      bus.beat_target = tgt;
      bus.timeout_cyc = tmo;
      @(negedge clk);
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.beat_target = ~tgt;
      bus.timeout_cyc = ~tmo;
      chk({tag, " clr_pulse"}, {bus.chk_rst, bus.busy, bus.done}, 3'b110);
      chk({tag, " clr_cleared"}, longint'(bus.beat_cnt) + bus.res_suc + bus.res_err +
          bus.pass + bus.abort_flag + bus.timeout_flag, 0);
      done_cyc = -1;
      glitch   = 0;
      for (int k = 0; k < ncyc + 8; k++) begin
         @(negedge clk);
         if (bus.done) begin done_cyc = k; break; end
         if (bus.chk_rst || !bus.busy) glitch++;
         bus.adc_vld = vld_a[k];
         bad         = bad_a[k];
         bus.stop    = stp_a[k];
         bus.start   = sta_a[k];
      end
      bus.adc_vld = 1'b0;
      bad         = 1'b0;
      bus.stop    = 1'b0;
      bus.start   = 1'b0;
      chk({tag, " busy_no_clr_in_run"}, glitch, 0);
   endtask

   task automatic check_res(input string tag, input int done_cyc, input res_t r);
      chk({tag, " done_cycle"}, done_cyc, r.done);
      chk({tag, " beat_cnt"},   bus.beat_cnt, r.beat);
      chk({tag, " res_suc"},    bus.res_suc, r.suc);
      chk({tag, " res_err"},    bus.res_err, r.err);
      chk({tag, " pass"},       bus.pass, r.pass);
      chk({tag, " abort_flag"}, bus.abort_flag, r.ab);
      chk({tag, " timeout_flag"}, bus.timeout_flag, r.to);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [9];
      res_t r;
      int   dc;
      int   tgt, tmo;

      vt[0] = '{16, 0, 16, -1, -1, -1, 18, 16, 16, 0, 1, 0, 0};
      vt[1] = '{ 8, 0,  8,  3, -1, -1, 10,  8,  7, 1, 0, 0, 0};
      vt[2] = '{100,5, 40, -1, -1, -1, 47, 40, 40, 0, 0, 0, 1};
      vt[3] = '{ 0, 0, 20, -1, 22, 10, 25, 20, 20, 0, 0, 1, 0};
      vt[4] = '{ 4, 0,  6, -1, -1, -1,  6,  4,  6, 0, 0, 0, 0};
      vt[5] = '{ 1, 0,  1, -1, -1, -1,  3,  1,  1, 0, 1, 0, 0};
      vt[6] = '{ 0, 1,  0, -1, -1, -1,  3,  0,  0, 0, 0, 0, 1};
      vt[7] = '{ 0, 0,  5, -1,  4, -1,  7,  5,  5, 0, 0, 1, 0};
      vt[8] = '{ 5, 3,  5, -1, -1, -1,  7,  5,  5, 0, 1, 0, 0};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.adc_vld = 1'b0; bad = 1'b0;
      bus.beat_target = '0; bus.timeout_cyc = '0;
      repeat (3) @(negedge clk);
      chk("reset flags", {bus.chk_rst, bus.busy, bus.done, bus.pass,
                          bus.timeout_flag, bus.abort_flag}, 0);
      chk("reset counts", longint'(bus.beat_cnt) + bus.res_suc + bus.res_err, 0);
      rst_n = 1'b1;

      // Directed table
      for (int v = 0; v < 9; v++) begin
         clear_arrays();
         for (int i = 0; i < vt[v].nb; i++) vld_a[i] = 1;
         if (vt[v].bad_idx  >= 0) bad_a[vt[v].bad_idx]  = 1;
         if (vt[v].stop_at  >= 0) stp_a[vt[v].stop_at]  = 1;
         if (vt[v].start_at >= 0) sta_a[vt[v].start_at] = 1;
         do_run(vt[v].tgt, vt[v].tmo, 60, 1'b0, $sformatf("vec%0d", v), dc);
         r = '{vt[v].e_done, vt[v].e_beat, vt[v].e_suc, vt[v].e_err,
               vt[v].e_pass, vt[v].e_ab, vt[v].e_to};
         check_res($sformatf("vec%0d", v), dc, r);
      end

      // Async reset in the middle of a run
      clear_arrays();
      @(negedge clk);
      bus.start = 1'b1; bus.beat_target = 32'd20; bus.timeout_cyc = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.adc_vld = 1'b1;
      end
      @(negedge clk);
      chk("mid_run beat_cnt", bus.beat_cnt, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst outputs", longint'(bus.beat_cnt) + bus.res_suc + bus.res_err +
          {bus.chk_rst, bus.busy, bus.done, bus.pass, bus.timeout_flag, bus.abort_flag}, 0);
      bus.adc_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Start with simultaneous stop in IDLE: stop must be ignored
      clear_arrays();
      for (int i = 0; i < 4; i++) vld_a[i] = 1;
      do_run(4, 0, 20, 1'b1, "post_rst", dc);
      r = '{6, 4, 4, 0, 1, 0, 0};
      check_res("post_rst", dc, r);

      // DONE holds; stop outside RUN has no effect
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_hold", {bus.done, bus.busy, bus.abort_flag, bus.pass}, 4'b1001);

      // Randomised runs against the model
      for (int n = 0; n < 40; n++) begin
         clear_arrays();
         tgt = $urandom_range(0, 12);
         tmo = $urandom_range(0, 4);
         for (int i = 0; i < 60; i++) begin
            vld_a[i] = ($urandom % 4) != 0;
            bad_a[i] = ($urandom % 8) == 0;
            stp_a[i] = ($urandom % 40) == 0;
            sta_a[i] = ($urandom % 30) == 0;
         end
         stp_a[59] = 1;
         r = model(tgt, tmo, 60);
         do_run(tgt, tmo, 60, 1'b0, $sformatf("rnd%0d", n), dc);
         check_res($sformatf("rnd%0d", n), dc, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
